// File: rtl/axis_ofmap_tx.sv
// axis_ofmap_tx: AXI4-Stream master that buffers core result words and sends them as fixed-length packets
// Ports:
//   aclk, areset        clock, synchronous active-high reset
//   wr_valid/wr_data    write port from the convertor core, wr_ready = !fifo_full
//   cfg_pkt_len         beats per packet (0 behaves as 1), latched at packet start
//   tx_enable           allows new beats to be loaded into the output register
//   M_AXIS_S2MM_*       stream master toward the DMA
//   pkt_done            one-cycle pulse after a TLAST beat transfers
//   pkt_count           packets completed since reset (wraps)
//   busy                packet in progress or data buffered
module axis_ofmap_tx #(
    parameter int TBITS = 64,
    parameter int TBYTE = 8,
    parameter int DEPTH = 16,
    parameter int LEN_W = 20
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             wr_valid,
    input  logic [TBITS-1:0] wr_data,
    output logic             wr_ready,
    input  logic [LEN_W-1:0] cfg_pkt_len,
    input  logic             tx_enable,
    output logic             M_AXIS_S2MM_TVALID,
    input  logic             M_AXIS_S2MM_TREADY,
    output logic [TBITS-1:0] M_AXIS_S2MM_TDATA,
    output logic [TBYTE-1:0] M_AXIS_S2MM_TKEEP,
    output logic             M_AXIS_S2MM_TLAST,
    output logic             pkt_done,
    output logic [15:0]      pkt_count,
    output logic             busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    typedef enum logic {IDLE, SEND} state_t;
    state_t state, state_next;
    logic [TBITS-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0] count;
    logic [LEN_W-1:0] beat_cnt, pkt_len_q, len_eff;
    logic [LEN_W:0] idx;
    logic [TBITS-1:0] ld_data;
    logic fifo_empty, push, xfer, load, pop, fifo_wr, pkt_start, last_next, last_xfer;
    assign wr_ready = count < FULL;
    assign M_AXIS_S2MM_TKEEP = '1;
    assign busy = state == SEND || !fifo_empty || M_AXIS_S2MM_TVALID;
    always_comb begin
        fifo_empty = count == '0;
        push = wr_valid && wr_ready;
        xfer = M_AXIS_S2MM_TVALID && M_AXIS_S2MM_TREADY;
        last_xfer = xfer && M_AXIS_S2MM_TLAST;
        // an empty FIFO lets the incoming word go straight into the output register
        load = (!M_AXIS_S2MM_TVALID || xfer) && tx_enable && (!fifo_empty || push);
        pop = load && !fifo_empty;
        fifo_wr = push && !(load && fifo_empty);
        ld_data = fifo_empty ? wr_data : mem[rptr];
        pkt_start = load && (state == IDLE || last_xfer);
        len_eff = !pkt_start ? pkt_len_q : (cfg_pkt_len == '0) ? LEN_W'(1) : cfg_pkt_len;
        // 1-based index of the beat being loaded: transferred beats, plus the one leaving now, plus one
        idx = pkt_start ? (LEN_W+1)'(1) : {1'b0, beat_cnt} + (LEN_W+1)'(xfer) + (LEN_W+1)'(1);
        last_next = idx == {1'b0, len_eff};
        state_next = pkt_start ? SEND : last_xfer ? IDLE : state;
    end
    always_ff @(posedge aclk) begin
        if (areset) state <= IDLE;
        else state <= state_next;
    end
    always_ff @(posedge aclk) begin
        if (fifo_wr) mem[wptr] <= wr_data;
    end
    always_ff @(posedge aclk) begin
        if (areset) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
            M_AXIS_S2MM_TVALID <= 1'b0;
            M_AXIS_S2MM_TDATA <= '0;
            M_AXIS_S2MM_TLAST <= 1'b0;
            pkt_len_q <= '0;
            beat_cnt <= '0;
            pkt_done <= 1'b0;
            pkt_count <= '0;
        end else begin
            if (fifo_wr) wptr <= wptr + AW'(1);
            if (pop) rptr <= rptr + AW'(1);
            if (fifo_wr && !pop) count <= count + (AW+1)'(1);
            else if (pop && !fifo_wr) count <= count - (AW+1)'(1);
            if (load) begin
                M_AXIS_S2MM_TVALID <= 1'b1;
                M_AXIS_S2MM_TDATA <= ld_data;
                M_AXIS_S2MM_TLAST <= last_next;
            end else if (xfer) begin
                M_AXIS_S2MM_TVALID <= 1'b0;
                M_AXIS_S2MM_TLAST <= 1'b0;
            end
            if (pkt_start) pkt_len_q <= len_eff;
            beat_cnt <= last_xfer ? '0 : xfer ? beat_cnt + LEN_W'(1) : beat_cnt;
            pkt_done <= last_xfer;
            pkt_count <= pkt_count + 16'(last_xfer);
        end
    end
endmodule

// File: tb/tb_axis_ofmap_tx.sv
// tb_axis_ofmap_tx: directed self-checking bench for axis_ofmap_tx with a beat scoreboard
module tb_axis_ofmap_tx;
    logic aclk = 1'b0;
    logic areset, wr_valid, wr_ready, tx_enable, tvalid, tready, tlast, pkt_done, busy;
    logic [63:0] wr_data, tdata;
    logic [19:0] cfg;
    logic [7:0] tkeep;
    logic [15:0] pkt_count;
    int tests = 0, fails = 0, cyc = 0, nbeats = 0, first_cyc = 0, last_cyc = 0, dones = 0;
    int acc, d0;
    bit tog = 0, hold = 0;
    logic pl, a;
    logic [63:0] pd;
    logic [64:0] e;
    logic [64:0] exp_q [$];

    axis_ofmap_tx dut (
        .aclk(aclk), .areset(areset), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .cfg_pkt_len(cfg), .tx_enable(tx_enable),
        .M_AXIS_S2MM_TVALID(tvalid), .M_AXIS_S2MM_TREADY(tready),
        .M_AXIS_S2MM_TDATA(tdata), .M_AXIS_S2MM_TKEEP(tkeep),
        .M_AXIS_S2MM_TLAST(tlast), .pkt_done(pkt_done), .pkt_count(pkt_count),
        .busy(busy)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
        if (tog) tready = ~tready;
    endtask

    task automatic push(input logic [63:0] d);
        int n = 0;
        wr_valid = 1'b1;
        wr_data = d;
        while (!wr_ready && n < 100) begin
            step();
            n++;
        end
        check("push_ready", wr_ready, 1);
        step();
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            step();
            n++;
        end
        check("drained", exp_q.size(), 0);
        step();
        step();
    endtask

    // stream monitor: AXI hold rule plus in-order scoreboard of transferred beats
    always @(negedge aclk) begin
        if (hold) begin
            check("hold_valid", tvalid, 1);
            check("hold_data", tdata, pd);
            check("hold_last", tlast, pl);
        end
        hold = tvalid && !tready && !areset;
        pd = tdata;
        pl = tlast;
        if (pkt_done) dones++;
        if (tvalid && tready && !areset) begin
            if (nbeats == 0) first_cyc = cyc;
            last_cyc = cyc;
            nbeats++;
            check("beat_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("tdata", tdata, e[63:0]);
                check("tlast", tlast, e[64]);
                check("tkeep", tkeep, 8'hff);
            end
        end
    end

    initial begin
        areset = 1; tready = 0; tx_enable = 1; wr_valid = 0; wr_data = 0; cfg = 1;
        step();
        step();
        check("rst_tvalid", tvalid, 0);
        check("rst_tlast", tlast, 0);
        check("rst_tdata", tdata, 0);
        check("rst_tkeep", tkeep, 8'hff);
        check("rst_wr_ready", wr_ready, 1);
        check("rst_pkt_done", pkt_done, 0);
        check("rst_pkt_count", pkt_count, 0);
        check("rst_busy", busy, 0);
        areset = 0;

        // full 1664-beat packet, streaming
        cfg = 1664; tready = 1; nbeats = 0; d0 = dones;
        for (int i = 0; i < 1664; i++) begin
            exp_q.push_back({i == 1663, 64'(i)});
            push(64'(i));
        end
        wr_valid = 0;
        drain();
        check("t1_beats", nbeats, 1664);
        check("t1_span", last_cyc - first_cyc, 1663);
        check("t1_done", dones - d0, 1);
        check("t1_count", pkt_count, 1);

        // backpressure with TREADY toggling
        cfg = 8; tog = 1;
        for (int i = 0; i < 8; i++) exp_q.push_back({i == 7, 64'(100 + i)});
        for (int i = 0; i < 8; i++) push(64'(100 + i));
        wr_valid = 0;
        drain();
        tog = 0; tready = 1;
        check("t2_count", pkt_count, 2);

        // full FIFO plus output register
        cfg = 18; tready = 0;
        step();
        for (int i = 0; i < 18; i++) exp_q.push_back({i == 17, 64'(200 + i)});
        wr_valid = 1; wr_data = 200; acc = 0;
        repeat (20) begin
            a = wr_ready;
            step();
            if (a) begin
                acc++;
                wr_data = wr_data + 1;
            end
        end
        check("t3_accepted", acc, 17);
        check("t3_full", wr_ready, 0);
        tready = 1;
        check("t3_full_pop", wr_ready, 0);
        step();
        tready = 0;
        check("t3_ready_back", wr_ready, 1);
        check("t3_head", tdata, 201);
        step();
        wr_valid = 0;
        check("t3_refull", wr_ready, 0);
        tready = 1;
        drain();
        check("t3_count", pkt_count, 3);

        // back-to-back 3-beat packets, then length 0
        cfg = 3; nbeats = 0;
        for (int i = 0; i < 9; i++) exp_q.push_back({(i % 3) == 2, 64'(300 + i)});
        for (int i = 0; i < 9; i++) push(64'(300 + i));
        wr_valid = 0;
        drain();
        check("t4_span", last_cyc - first_cyc, 8);
        check("t4_count", pkt_count, 6);
        cfg = 0;
        exp_q.push_back({1'b1, 64'(400)});
        exp_q.push_back({1'b1, 64'(401)});
        push(400);
        push(401);
        wr_valid = 0;
        drain();
        check("t4_len0_count", pkt_count, 8);

        // length change mid-packet, then tx_enable gating
        cfg = 4;
        for (int i = 0; i < 4; i++) exp_q.push_back({i == 3, 64'(500 + i)});
        push(500);
        cfg = 2;
        for (int i = 1; i < 4; i++) push(64'(500 + i));
        wr_valid = 0;
        drain();
        check("t5_count", pkt_count, 9);
        tready = 0;
        exp_q.push_back({1'b0, 64'(600)});
        exp_q.push_back({1'b1, 64'(601)});
        push(600);
        tx_enable = 0;
        push(601);
        wr_valid = 0;
        step();
        step();
        check("t5_hold_valid", tvalid, 1);
        check("t5_hold_data", tdata, 600);
        tready = 1;
        step();
        tready = 0;
        check("t5_no_load", tvalid, 0);
        check("t5_busy", busy, 1);
        step();
        step();
        check("t5_still_blocked", tvalid, 0);
        tx_enable = 1;
        step();
        check("t5_load_valid", tvalid, 1);
        check("t5_load_data", tdata, 601);
        check("t5_load_last", tlast, 1);
        tready = 1;
        drain();
        check("t5_count2", pkt_count, 10);

        // reset mid-packet with words buffered
        cfg = 10;
        for (int i = 0; i < 5; i++) exp_q.push_back({1'b0, 64'(700 + i)});
        for (int i = 0; i < 5; i++) push(64'(700 + i));
        wr_valid = 0;
        step();
        tready = 0;
        for (int i = 5; i < 11; i++) push(64'(700 + i));
        wr_valid = 0;
        check("t6_busy_before", busy, 1);
        areset = 1;
        step();
        check("t6_tvalid", tvalid, 0);
        check("t6_tlast", tlast, 0);
        check("t6_tdata", tdata, 0);
        check("t6_wr_ready", wr_ready, 1);
        check("t6_pkt_done", pkt_done, 0);
        check("t6_pkt_count", pkt_count, 0);
        check("t6_busy", busy, 0);
        areset = 0;
        cfg = 2; tready = 1;
        exp_q.push_back({1'b0, 64'(800)});
        exp_q.push_back({1'b1, 64'(801)});
        push(800);
        push(801);
        wr_valid = 0;
        drain();
        check("t6_count", pkt_count, 1);
        check("t6_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
